// File: rtl/controller_reader_m_pkg.sv
// Shared types and constants for the dual NES-style gamepad reader.
// Holds the poll FSM state encoding and the button bit map.
package controller_reader_m_pkg;

    localparam int unsigned NUM_PADS     = 2;
    localparam int unsigned BITS_PER_PAD = 8;

    // Button bit positions in a committed pad byte (1 = pressed)
    localparam int unsigned BTN_A      = 0;
    localparam int unsigned BTN_B      = 1;
    localparam int unsigned BTN_SELECT = 2;
    localparam int unsigned BTN_START  = 3;
    localparam int unsigned BTN_UP     = 4;
    localparam int unsigned BTN_DOWN   = 5;
    localparam int unsigned BTN_LEFT   = 6;
    localparam int unsigned BTN_RIGHT  = 7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LATCH  = 2'd1,
        ST_SHIFT  = 2'd2,
        ST_COMMIT = 2'd3
    } state_e;

endpackage : controller_reader_m_pkg

// File: rtl/controller_reader_m_synchronizer.sv
// Two-flop synchronizer with parameterized width and reset value,
// used to bring the asynchronous pad data lines into the clock domain.
module synchronizer_m #(
    parameter int unsigned           WIDTH     = 1,
    parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r <= RESET_VAL;
            sync_r <= RESET_VAL;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule : synchronizer_m

// File: rtl/controller_reader_m.sv
// Polls two serial gamepads on request and serves the last complete
// button state of each pad to CPU reads of the controller range.
module controller_reader_m
    import controller_reader_m_pkg::*;
#(
    parameter int unsigned BIT_CYCLES = 76
) (
    input  logic                clk_12_5875,
    input  logic                rst,
    input  logic                start,
    input  logic                SELECT_controller,
    input  logic                address,
    input  logic                write_enable,
    output logic [7:0]          data_out,
    output logic                data_enable,
    output logic                ctrl_latch,
    output logic                ctrl_clk,
    input  logic [NUM_PADS-1:0] ctrl_data_B,
    output logic                busy
);

    localparam int unsigned   CW        = $clog2(BIT_CYCLES);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BIT_CYCLES / 2 - 1);
    localparam logic [2:0]    BIT_LAST  = 3'd7;

    state_e                                   state_r;
    state_e                                   state_nxt_s;
    logic [CW-1:0]                            cnt_r;
    logic [CW-1:0]                            cnt_nxt_s;
    logic [2:0]                               bit_r;
    logic [2:0]                               bit_nxt_s;
    logic                                     sample_s;
    logic                                     commit_s;
    logic [NUM_PADS-1:0]                      data_sync_s;
    logic [NUM_PADS-1:0][BITS_PER_PAD-1:0]    shadow_r;
    logic [NUM_PADS-1:0][BITS_PER_PAD-1:0]    visible_r;
    logic                                     latch_r;
    logic                                     clk_out_r;
    logic                                     busy_r;

    synchronizer_m #(
        .WIDTH     (NUM_PADS),
        .RESET_VAL ({NUM_PADS{1'b1}})
    ) u_data_sync (
        .clk (clk_12_5875),
        .rst (rst),
        .d   (ctrl_data_B),
        .q   (data_sync_s)
    );

    // Poll sequencing: latch pulse, eight shift periods, one commit cycle
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        bit_nxt_s   = bit_r;
        sample_s    = 1'b0;
        commit_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_LATCH;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LATCH: begin
                if (cnt_r == CNT_LAST) begin
                    state_nxt_s = ST_SHIFT;
                    cnt_nxt_s   = CNT_ZERO;
                    bit_nxt_s   = 3'd0;
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end
            ST_SHIFT: begin
                // Data has settled through the synchronizer by the end of the low half
                if (cnt_r == HALF_LAST) begin
                    sample_s = 1'b1;
                end else begin
                    sample_s = 1'b0;
                end
                if (cnt_r == CNT_LAST) begin
                    cnt_nxt_s = CNT_ZERO;
                    if (bit_r == BIT_LAST) begin
                        state_nxt_s = ST_COMMIT;
                    end else begin
                        bit_nxt_s = bit_r + 3'd1;
                    end
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            ST_COMMIT: begin
                commit_s    = 1'b1;
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = CNT_ZERO;
                bit_nxt_s   = 3'd0;
            end
        endcase
    end

    // State, shift registers, and pad outputs decoded from the next state
    always_ff @(posedge clk_12_5875) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= CNT_ZERO;
            bit_r     <= 3'd0;
            shadow_r  <= '0;
            visible_r <= '0;
            latch_r   <= 1'b0;
            clk_out_r <= 1'b1;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            bit_r     <= bit_nxt_s;
            if (sample_s) begin
                for (int p = 0; p < NUM_PADS; p++) begin
                    shadow_r[p] <= {~data_sync_s[p], shadow_r[p][BTN_RIGHT:BTN_B]};
                end
            end
            // Both pads update on the same edge so a read never sees a mix of polls
            if (commit_s) begin
                visible_r <= shadow_r;
            end
            latch_r   <= (state_nxt_s == ST_LATCH);
            clk_out_r <= ~((state_nxt_s == ST_SHIFT) && (cnt_nxt_s <= HALF_LAST));
            busy_r    <= (state_nxt_s != ST_IDLE);
        end
    end

    // CPU read port
    always_comb begin
        data_enable = SELECT_controller & ~write_enable;
        if (data_enable) begin
            data_out = visible_r[address];
        end else begin
            data_out = 8'h00;
        end
    end

    assign ctrl_latch = latch_r;
    assign ctrl_clk   = clk_out_r;
    assign busy       = busy_r;

endmodule : controller_reader_m

// File: tb/tb_controller_reader_m.sv
// Directed bench for controller_reader_m with two behavioural NES pad models.
module tb_controller_reader_m;

    logic       clk;
    logic       rst;
    logic       start;
    logic       sel;
    logic       address;
    logic       write_enable;
    logic [7:0] data_out;
    logic       data_enable;
    logic       ctrl_latch;
    logic       ctrl_clk;
    logic [1:0] ctrl_data_B;
    logic       busy;

    logic [7:0] pad0_btn;
    logic [7:0] pad1_btn;
    logic [7:0] sr0;
    logic [7:0] sr1;
    logic       clk_prev;
    logic       force_en;
    logic [1:0] force_val;

    int errors = 0;
    int checks = 0;
    int nb, nl, nr, nle, idle_busy;

    controller_reader_m #(.BIT_CYCLES(8)) dut (
        .clk_12_5875       (clk),
        .rst               (rst),
        .start             (start),
        .SELECT_controller (sel),
        .address           (address),
        .write_enable      (write_enable),
        .data_out          (data_out),
        .data_enable       (data_enable),
        .ctrl_latch        (ctrl_latch),
        .ctrl_clk          (ctrl_clk),
        .ctrl_data_B       (ctrl_data_B),
        .busy              (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pad model: load on latch, shift on rising ctrl_clk, active-low serial out
    always @(posedge clk) begin
        clk_prev <= ctrl_clk;
        if (rst) begin
            sr0 <= 8'h00;
            sr1 <= 8'h00;
        end else if (ctrl_latch) begin
            sr0 <= pad0_btn;
            sr1 <= pad1_btn;
        end else if (ctrl_clk && !clk_prev) begin
            sr0 <= {1'b0, sr0[7:1]};
            sr1 <= {1'b0, sr1[7:1]};
        end
    end

    assign ctrl_data_B = force_en ? force_val : {~sr1[0], ~sr0[0]};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic read_pad(input string tag, input logic a, input logic [7:0] exp);
        sel = 1'b1;
        write_enable = 1'b0;
        address = a;
        #1;
        check(tag, {24'h0, data_out}, {24'h0, exp});
    endtask

    // Runs one poll, counting busy/latch cycles and ctrl_clk rises; optionally
    // re-pulses start at cycle restart_at and checks pad0 reads the old value.
    task automatic poll(input int restart_at, input bit chk_old, input logic [7:0] old_val,
                        output int busy_n, output int latch_n, output int rise_n,
                        output int latch_edges);
        logic prev_clk;
        logic prev_latch;
        busy_n = 0; latch_n = 0; rise_n = 0; latch_edges = 0;
        prev_clk = 1'b1; prev_latch = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!busy) break;
            busy_n++;
            if (ctrl_latch) latch_n++;
            if (ctrl_latch && !prev_latch) latch_edges++;
            if (ctrl_clk && !prev_clk) rise_n++;
            prev_clk = ctrl_clk;
            prev_latch = ctrl_latch;
            if (chk_old) read_pad("midpoll_read", 1'b0, old_val);
            start = (i == restart_at);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; sel = 1'b0; address = 1'b0; write_enable = 1'b0;
        pad0_btn = 8'h00; pad1_btn = 8'h00; force_en = 1'b0; force_val = 2'b11;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_latch", {31'h0, ctrl_latch}, 32'd0);
        check("rst_clk", {31'h0, ctrl_clk}, 32'd1);
        check("rst_busy", {31'h0, busy}, 32'd0);
        read_pad("rst_read0", 1'b0, 8'h00);
        check("rst_den", {31'h0, data_enable}, 32'd1);
        read_pad("rst_read1", 1'b1, 8'h00);

        // Basic poll: pad0 A+Start, pad1 Left+Right
        pad0_btn = 8'h09; pad1_btn = 8'hC0;
        @(negedge clk);
        poll(-1, 1'b0, 8'h00, nb, nl, nr, nle);
        check("p1_busy", nb, 32'd73);
        check("p1_latch", nl, 32'd8);
        check("p1_rises", nr, 32'd8);
        read_pad("p1_pad0", 1'b0, 8'h09);
        read_pad("p1_pad1", 1'b1, 8'hC0);

        // Start during SHIFT is ignored
        poll(30, 1'b0, 8'h00, nb, nl, nr, nle);
        check("p2_busy", nb, 32'd73);
        check("p2_latch", nl, 32'd8);
        check("p2_latch_edges", nle, 32'd1);
        idle_busy = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy || ctrl_latch) idle_busy++;
            @(negedge clk);
        end
        check("p2_no_second", idle_busy, 32'd0);

        // Old value visible until the cycle after COMMIT
        pad0_btn = 8'h02;
        poll(-1, 1'b1, 8'h09, nb, nl, nr, nle);
        read_pad("p3_new_pad0", 1'b0, 8'h02);
        read_pad("p3_pad1", 1'b1, 8'hC0);
        write_enable = 1'b1;
        #1;
        check("p3_wr_den", {31'h0, data_enable}, 32'd0);
        check("p3_wr_data", {24'h0, data_out}, 32'h00);
        write_enable = 1'b0;
        @(negedge clk);

        // Reset during SHIFT bit 4
        pad0_btn = 8'hFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (42) @(negedge clk);
        check("r_pre_busy", {31'h0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("r_latch", {31'h0, ctrl_latch}, 32'd0);
        check("r_clk", {31'h0, ctrl_clk}, 32'd1);
        check("r_busy", {31'h0, busy}, 32'd0);
        read_pad("r_pad0", 1'b0, 8'h00);
        read_pad("r_pad1", 1'b1, 8'h00);
        @(negedge clk);
        check("r_still_idle", {31'h0, busy}, 32'd0);

        pad0_btn = 8'h02;
        poll(-1, 1'b0, 8'h00, nb, nl, nr, nle);
        check("r2_busy", nb, 32'd73);
        read_pad("r2_pad0", 1'b0, 8'h02);
        read_pad("r2_pad1", 1'b1, 8'hC0);

        // Unplugged (high) pad0, stuck-low pad1
        force_en = 1'b1; force_val = 2'b01;
        repeat (3) @(negedge clk);
        poll(-1, 1'b0, 8'h00, nb, nl, nr, nle);
        read_pad("f_pad0", 1'b0, 8'h00);
        read_pad("f_pad1", 1'b1, 8'hFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_controller_reader_m
